// File: rtl/ref_ram_pkg.sv
// Shared constants, FSM encoding and bandwidth-to-bank mapping for the
// preamble reference memory writer.
package ref_ram_pkg;

  localparam logic [2:0] cBW_IDX_0 = 3'd0;
  localparam logic [2:0] cBW_IDX_5 = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic ok;
    logic bank;
  } bank_sel_t;

  function automatic bank_sel_t bw_to_bank(input logic [2:0] index);
    bank_sel_t sel;
    sel.ok   = 1'b0;
    sel.bank = 1'b0;
    case (index)
      cBW_IDX_0: sel.ok = 1'b1;
      cBW_IDX_5: begin
        sel.ok   = 1'b1;
        sel.bank = 1'b1;
      end
      default: ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ref_ram_writer_if.sv
// Load stream, status and read port of ref_ram_writer.
// REF_RAM_WR_CHECKSUM_EN adds the ocsum status signal.
interface ref_ram_writer_if #(
   parameter int pDAT_W    = 24,
   parameter int pDAT_Num  = 1024,
   parameter int pBANK_NUM = 2
);
   localparam int cAW = $clog2(pDAT_Num);

   logic                 istart;
   logic [2:0]           index_bw;
   logic [pDAT_W-1:0]    idat;
   logic                 ival;
   logic                 ordy;
   logic                 obusy;
   logic                 odone;
   logic                 oerr;
   logic [pBANK_NUM-1:0] obank_vld;
   logic                 irden;
   logic [2:0]           irdbw;
   logic [cAW-1:0]       irdaddr;
   logic [pDAT_W-1:0]    odat;
   logic                 odat_val;
`ifdef REF_RAM_WR_CHECKSUM_EN
   logic [pDAT_W-1:0]    ocsum;

   modport master (
      output istart, index_bw, idat, ival, irden, irdbw, irdaddr,
      input  ordy, obusy, odone, oerr, obank_vld, odat, odat_val, ocsum
   );
   modport slave (
      input  istart, index_bw, idat, ival, irden, irdbw, irdaddr,
      output ordy, obusy, odone, oerr, obank_vld, odat, odat_val, ocsum
   );
`else
   modport master (
      output istart, index_bw, idat, ival, irden, irdbw, irdaddr,
      input  ordy, obusy, odone, oerr, obank_vld, odat, odat_val
   );
   modport slave (
      input  istart, index_bw, idat, ival, irden, irdbw, irdaddr,
      output ordy, obusy, odone, oerr, obank_vld, odat, odat_val
   );
`endif

endinterface

// File: rtl/ref_ram_bank.sv
// One reference bank: simple dual-port RAM, one write port and a
// registered read-first read port.
module ref_ram_bank #(
   parameter int pDAT_W   = 24,
   parameter int pDAT_Num = 1024,
   localparam int cAW     = $clog2(pDAT_Num)
) (
   input  logic              iclk,
   input  logic              iwe,
   input  logic [cAW-1:0]    iwaddr,
   input  logic [pDAT_W-1:0] iwdat,
   input  logic              irden,
   input  logic [cAW-1:0]    irdaddr,
   output logic [pDAT_W-1:0] ordat
);

   logic [pDAT_W-1:0] mem [pDAT_Num];

   // NOTE: the array has no reset so it maps onto block RAM; whether a bank
   // holds meaningful data is tracked by the writer's obank_vld flags.
   always_ff @(posedge iclk) begin
      if (iwe)
         mem[iwaddr] <= iwdat;
      // Same-address read during a write sees the old word (read-first).
      if (irden)
         ordat <= mem[irdaddr];
   end

endmodule

// File: rtl/ref_ram_writer.sv
// Run-time loader and read port for the frequency-domain preamble reference.
// REF_RAM_WR_CHECKSUM_EN adds ocsum, the XOR of the last completed load.
module ref_ram_writer
   import ref_ram_pkg::*;
#(
   parameter int pDAT_W    = 24,
   parameter int pDAT_Num  = 1024,
   parameter int pBANK_NUM = 2
) (
   input logic             iclk,
   input logic             irst,
   ref_ram_writer_if.slave bus
);

   localparam int             cAW   = $clog2(pDAT_Num);
   localparam logic [cAW-1:0] cLAST = cAW'(pDAT_Num - 1);

   state_t               state;
   logic                 bank;
   logic [cAW-1:0]       waddr;
   logic [pBANK_NUM-1:0] bank_vld;
   logic                 err;
   logic                 rd_ok;
   logic                 rd_bank;
   logic                 rd_val;
   logic                 xfer;
   logic                 load_start;
   bank_sel_t            start_sel;
   bank_sel_t            rd_sel;
   logic [pDAT_W-1:0]    bank_q [pBANK_NUM];

   assign start_sel  = bw_to_bank(bus.index_bw);
   assign rd_sel     = bw_to_bank(bus.irdbw);
   assign xfer       = (state == LOAD) && bus.ival;
   assign load_start = (state == IDLE) && bus.istart && start_sel.ok;

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state    <= IDLE;
         bank     <= 1'b0;
         waddr    <= '0;
         bank_vld <= '0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.istart) begin
                  if (start_sel.ok) begin
                     state              <= LOAD;
                     bank               <= start_sel.bank;
                     waddr              <= '0;
                     bank_vld[start_sel.bank] <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (bus.ival) begin
                  if (waddr == cLAST)
                     state <= DONE;
                  else
                     waddr <= waddr + cAW'(1);
               end
            end
            DONE: begin
               state          <= IDLE;
               bank_vld[bank] <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef REF_RAM_WR_CHECKSUM_EN
   logic [pDAT_W-1:0] csum_run;
   logic [pDAT_W-1:0] csum;

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         csum_run <= '0;
         csum     <= '0;
      end else begin
         if (load_start)
            csum_run <= '0;
         else if (xfer)
            csum_run <= csum_run ^ bus.idat;
         if (state == DONE)
            csum <= csum_run;
      end
   end

   assign bus.ocsum = csum;
`endif

   // Select and validity are captured only on a read so odat holds between reads.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         rd_ok   <= 1'b0;
         rd_bank <= 1'b0;
         rd_val  <= 1'b0;
      end else begin
         rd_val <= bus.irden;
         if (bus.irden) begin
            rd_ok   <= rd_sel.ok;
            rd_bank <= rd_sel.bank;
         end
      end
   end

   for (genvar g = 0; g < pBANK_NUM; g++) begin : g_bank
      ref_ram_bank #(
         .pDAT_W   (pDAT_W),
         .pDAT_Num (pDAT_Num)
      ) u_bank (
         .iclk    (iclk),
         .iwe     (xfer && (bank == 1'(g))),
         .iwaddr  (waddr),
         .iwdat   (bus.idat),
         .irden   (bus.irden),
         .irdaddr (bus.irdaddr),
         .ordat   (bank_q[g])
      );
   end

   assign bus.ordy      = (state == LOAD);
   assign bus.obusy     = (state != IDLE);
   assign bus.odone     = (state == DONE);
   assign bus.oerr      = err;
   assign bus.obank_vld = bank_vld;
   assign bus.odat      = rd_ok ? bank_q[rd_bank] : '0;
   assign bus.odat_val  = rd_val;

endmodule

// File: tb/tb_ref_ram_writer.sv
// Randomized scoreboard bench for ref_ram_writer with a word-level reference model.
// Build with REF_RAM_WR_CHECKSUM_EN to also check ocsum.
module tb_ref_ram_writer;

   localparam int W  = 24;
   localparam int N  = 1024;
   localparam int AW = 10;

   logic iclk = 1'b0;
   logic irst = 1'b1;
   always #5 iclk = ~iclk;

   ref_ram_writer_if #(.pDAT_W(W), .pDAT_Num(N), .pBANK_NUM(2)) bus ();

   ref_ram_writer #(.pDAT_W(W), .pDAT_Num(N), .pBANK_NUM(2)) dut (
      .iclk (iclk),
      .irst (irst),
      .bus  (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: memory image, load progress and status flags.
   logic [W-1:0] ref_mem [2][N];
   bit           known   [2][N];
   logic [W-1:0] exp_q [$];
   logic [W-1:0] last_dat = '0;
   int           m_phase = 0;   // 0 idle, 1 loading, 2 done pulse
   int           m_addr  = 0;
   int           m_bank  = 0;
   logic [1:0]   m_vld   = 2'b00;
   logic         m_err   = 1'b0;
   logic         prev_done = 1'b0;
   logic [W-1:0] m_run   = '0;
   logic [W-1:0] m_csum  = '0;
   int           odone_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] dat_of(input int mode, input int a);
      case (mode)
         0:       return W'(a);
         1:       return ~W'(a);
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: compares every presented read against the scoreboard.
   always @(negedge iclk) begin
      logic [W-1:0] exp;
      if (!irst) begin
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("rd_val", 64'(bus.odat_val), 64'(1));
            check("rd_dat", 64'(bus.odat), 64'(exp));
            last_dat = exp;
         end else begin
            check("rd_val_idle", 64'(bus.odat_val), 64'(0));
            check("rd_hold", 64'(bus.odat), 64'(last_dat));
         end
      end
   end

   // One clock of stimulus: check status against the model, drive, advance the model.
   task automatic cyc(input logic st, input logic [2:0] bw, input logic v, input logic [W-1:0] d,
                      input logic re, input logic [2:0] rbw, input logic [AW-1:0] ra);
      logic ok;
      int   b;
      @(negedge iclk);
      #1;
      check("ordy",  64'(bus.ordy),  64'(m_phase == 1));
      check("obusy", 64'(bus.obusy), 64'(m_phase != 0));
      check("odone", 64'(bus.odone), 64'(m_phase == 2));
      check("oerr",  64'(bus.oerr),  64'(m_err));
      if (m_phase == 1 || (m_phase == 0 && !prev_done))
         check("obank_vld", 64'(bus.obank_vld), 64'(m_vld));
`ifdef REF_RAM_WR_CHECKSUM_EN
      if (m_phase == 0 && !prev_done)
         check("ocsum", 64'(bus.ocsum), 64'(m_csum));
`endif
      if (bus.odone) odone_cnt++;

      bus.istart   = st;
      bus.index_bw = bw;
      bus.ival     = v;
      bus.idat     = d;
      bus.irden    = re;
      bus.irdbw    = rbw;
      bus.irdaddr  = ra;

      if (re) begin
         ok = (rbw == 3'd0) || (rbw == 3'd5);
         b  = (rbw == 3'd5) ? 1 : 0;
         exp_q.push_back(ok ? ref_mem[b][ra] : '0);
      end

      prev_done = (m_phase == 2);
      m_err     = 1'b0;
      case (m_phase)
         0: if (st) begin
               if (bw == 3'd0 || bw == 3'd5) begin
                  m_phase = 1;
                  m_bank  = (bw == 3'd5) ? 1 : 0;
                  m_addr  = 0;
                  m_vld[m_bank] = 1'b0;
                  m_run   = '0;
               end else begin
                  m_err = 1'b1;
               end
            end
         1: if (v) begin
               ref_mem[m_bank][m_addr] = d;
               known[m_bank][m_addr]   = 1'b1;
               m_run = m_run ^ d;
               if (m_addr == N - 1) m_phase = 2;
               else m_addr++;
            end
         default: begin
            m_phase = 0;
            m_vld[m_bank] = 1'b1;
            m_csum  = m_run;
         end
      endcase
   endtask

   task automatic pick_rd(output logic re, output logic [2:0] rbw, output logic [AW-1:0] ra);
      int b;
      case ($urandom % 4)
         0:       rbw = 3'd0;
         1:       rbw = 3'd5;
         2:       rbw = 3'($urandom);
         default: rbw = 3'd3;
      endcase
      ra = AW'($urandom);
      b  = (rbw == 3'd5) ? 1 : 0;
      re = !((rbw == 3'd0 || rbw == 3'd5) && !known[b][ra]);
   endtask

   task automatic idle_rd(input int n);
      logic re; logic [2:0] rbw; logic [AW-1:0] ra;
      for (int i = 0; i < n; i++) begin
         pick_rd(re, rbw, ra);
         cyc(1'b0, 3'd0, 1'b0, '0, re & ($urandom % 2 == 0), rbw, ra);
      end
   endtask

   // vmode: 0 ival held high, 1 ival toggling 1010..., 2 random ival.
   task automatic do_load(input logic [2:0] bw, input int dmode, input int vmode, input int abort_at);
      int n; int start_cnt;
      logic v; logic re; logic [2:0] rbw; logic [AW-1:0] ra;
      start_cnt = odone_cnt;
      cyc(1'b1, bw, 1'b0, '0, 1'b0, 3'd0, '0);
      n = 0;
      for (int c = 0; c < 4 * N && m_phase != 0; c++) begin
         if (abort_at >= 0 && n == abort_at) return;
         case (vmode)
            0:       v = 1'b1;
            1:       v = (c % 2 == 0);
            default: v = ($urandom % 3 != 0);
         endcase
         if (v && m_phase == 1 && known[m_bank][m_addr] && (m_addr == 5 || $urandom % 8 == 0)) begin
            re = 1'b1; rbw = bw; ra = AW'(m_addr);
         end else begin
            pick_rd(re, rbw, ra);
            re = re & ($urandom % 4 == 0);
         end
         if (v && m_phase == 1) n++;
         cyc(($urandom % 16 == 0), 3'($urandom), v, dat_of(dmode, m_addr), re, rbw, ra);
      end
      check("odone_once", 64'(odone_cnt - start_cnt), 64'(1));
   endtask

   task automatic rst_mid();
      @(negedge iclk);
      #2;
      irst = 1'b1;
      #1;
      check("rst_outs", 64'({bus.ordy, bus.obusy, bus.odone, bus.oerr, bus.obank_vld,
                              bus.odat_val, bus.odat}), 64'(0));
      bus.istart = 1'b0; bus.index_bw = '0; bus.idat = '0; bus.ival = 1'b0;
      bus.irden  = 1'b0; bus.irdbw = '0; bus.irdaddr = '0;
      exp_q.delete();
      m_phase = 0; m_vld = 2'b00; m_err = 1'b0; prev_done = 1'b0;
      m_run = '0; m_csum = '0; last_dat = '0;
      repeat (2) @(negedge iclk);
      #1;
      irst = 1'b0;
   endtask

   initial begin
      bus.istart = 1'b0; bus.index_bw = '0; bus.idat = '0; bus.ival = 1'b0;
      bus.irden  = 1'b0; bus.irdbw = '0; bus.irdaddr = '0;

      rst_mid();
      idle_rd(3);

      // Full load of bank 0 with idat=addr, then directed reads.
      do_load(3'd0, 0, 0, -1);
      idle_rd(2);
      cyc(1'b0, 3'd0, 1'b0, '0, 1'b1, 3'd0, AW'(17));
      cyc(1'b0, 3'd0, 1'b0, '0, 1'b1, 3'd0, AW'(1023));
      cyc(1'b0, 3'd0, 1'b0, '0, 1'b0, 3'd0, '0);

      // Back-pressured load of bank 1 with idat=~addr, then full readback.
      do_load(3'd5, 1, 1, -1);
      idle_rd(2);
      for (int a = 0; a < N; a++)
         cyc(1'b0, 3'd0, 1'b0, '0, 1'b1, 3'd5, AW'(a));
      for (int a = 0; a < 16; a++)
         cyc(1'b0, 3'd0, 1'b0, '0, 1'b1, 3'd0, AW'($urandom));

      // Unsupported index on start and on read.
      cyc(1'b1, 3'd3, 1'b0, '0, 1'b0, 3'd0, '0);
      cyc(1'b0, 3'd0, 1'b0, '0, 1'b1, 3'd3, AW'(9));
      idle_rd(3);

      // Reset part-way into a random-data load of bank 0, then reload it.
      do_load(3'd0, 2, 2, 500);
      rst_mid();
      idle_rd(3);
      do_load(3'd0, 0, 2, -1);
      idle_rd(4);

      cyc(1'b0, 3'd0, 1'b0, '0, 1'b0, 3'd0, '0);
      check("q_empty", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ref_ram_writer.md
Name: ref_ram_writer

Overview:
Write side of the frequency-domain preamble reference memory used by freq_correct in the Rx path. It accepts a streamed preamble reference (one word per bin) for a chosen bandwidth index and stores it in that bandwidth's bank. It also provides a registered read port for the correlator, so reference tables are loaded at run time rather than baked into ROM.

Parameters:
pDAT_W, 24, width of one reference word (packed I/Q)
pDAT_Num, 1024, words per bank (FFT bins); power of two
pBANK_NUM, 2, number of banks; bank 0 = index_bw 0, bank 1 = index_bw 5

Ports:
iclk  in  1  clock
irst  in  1  reset, asynchronous, active-high
istart  in  1  start a load; sampled only in IDLE
index_bw  in  3  bandwidth index for the load; latched on accepted istart
idat  in  pDAT_W  reference word to write
ival  in  1  idat valid
ordy  out  1  writer ready; a word transfers when ival && ordy
obusy  out  1  high in LOAD and DONE
odone  out  1  1-cycle pulse after the last word is written
oerr  out  1  1-cycle pulse when istart carries an unsupported index_bw
obank_vld  out  pBANK_NUM  per-bank "fully loaded" flags
irden  in  1  read enable
irdbw  in  3  bandwidth index for the read
irdaddr  in  $clog2(pDAT_Num)  read address
odat  out  pDAT_W  read data
odat_val  out  1  read data valid

Behaviour:
- Reset values: ordy=0, obusy=0, odone=0, oerr=0, obank_vld=0, odat=0, odat_val=0, FSM=IDLE, write address=0. RAM contents are not reset.
- FSM states:
  - IDLE: istart=1 with index_bw in {0,5} -> latch bank, write address=0, go to LOAD. ordy rises the following cycle.
  - IDLE, unsupported index: istart=1 with any other index_bw -> oerr=1 for one cycle, stay in IDLE.
  - LOAD: ordy=1. Each ival&&ordy writes idat to mem[bank][addr], then addr+1.
  - LOAD clears the target bank's obank_vld bit on entry.
  - LOAD exit: when the transfer at addr==pDAT_Num-1 occurs, go to DONE. ordy is 0 from the next cycle, so there is no wrap to address 0.
  - DONE (1 cycle): odone=1, set obank_vld[bank], go to IDLE.
- istart in LOAD or DONE is ignored. A new load may start the cycle after DONE, i.e. in IDLE.
- ival while ordy=0: no write, data dropped. The upstream source must hold data until ordy is high.
- Read path:
  - Latency 1. irden=1 at cycle N -> odat/odat_val valid at N+1. odat_val=irden delayed by one cycle.
  - irdbw 0 -> bank 0; irdbw 5 -> bank 1.
  - Any other irdbw -> odat=0 with odat_val=1.
  - irden=0 -> odat holds its last value and odat_val=0.
- Read/write collision: reading the bank currently being written is permitted. Reading the address being written in the same cycle returns the old data (read-first).
- Reset mid-load: FSM returns to IDLE and all obank_vld bits clear. Partial RAM contents stay but are flagged invalid.

Optional Feature:
Macro REF_RAM_WR_CHECKSUM_EN.
- Defined: adds output ocsum [pDAT_W-1:0], the XOR of all words written in the last completed load.
  - The running XOR resets to 0 on LOAD entry.
  - ocsum updates in the DONE cycle. Reset value 0.
- Undefined: the ocsum port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ref_ram_pkg holds:
  - constants cBW_IDX_0=3'd0 and cBW_IDX_5=3'd5
  - FSM state enum {IDLE, LOAD, DONE}
  - function bw_to_bank(index) returning a bank number plus a supported flag
- Sub-module ref_ram_bank: simple dual-port RAM, one write port, one registered read-first read port, pDAT_W x pDAT_Num. Instantiated pBANK_NUM times.
- The top holds the FSM, address counter, flags and read mux.

Test Plan:
- Reset: assert irst mid-cycle -> all outputs 0 asynchronously. Release -> ordy=0, obank_vld=2'b00.
- Full load, bank 0: istart with index_bw=0, then 1024 words idat=addr with ival held high.
  - odone pulses exactly once, 1 cycle after word 1023; obank_vld=2'b01.
  - Read irdbw=0, irdaddr=17 -> odat=17 one cycle later.
- Back-pressure: load bank 1 (index_bw=5) with ival toggling 1010… and idat=~addr.
  - Exactly 1024 writes occur.
  - Read irdaddr=1023 -> odat=~1023 (truncated to pDAT_W); bank 0 data unchanged.
- Illegal index: istart with index_bw=3 -> oerr pulse of 1 cycle, FSM stays IDLE, ordy stays 0. A read with irdbw=3 returns odat=0 with odat_val=1.
- Reset mid-load: irst after 500 words into bank 0 -> obank_vld[0]=0. A new full load then completes normally with obank_vld[0]=1.
- Collision and checksum:
  - Read addr 5 of bank 0 in the same cycle word 5 is rewritten -> old value returned.
  - With REF_RAM_WR_CHECKSUM_EN defined, loading idat=addr for 1024 words -> ocsum=0.
